// File: rtl/uart_rx_if.sv
// Serial line plus received-word bundle between the UART receive engine and its consumer.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx,
        output rx_data, rx_valid, parity_err, frame_err, busy
    );

    modport slave (
        output rx,
        input  rx_data, rx_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronised serial line in, one-clock valid strobe with word and error flags out.
// Optional UART_RX_MAJORITY_VOTE_EN: 3-sample majority vote on every bit decision.
module uart_rx_engine #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.master  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] H_CNT     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] F_CNT     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_pend;
    logic                 frm_pend;
    logic                 rx_m, rx_s, rx_d;
    logic                 start_det;
    logic                 sample;
    logic                 at_h, at_f;

    function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
        if (PARITY_MODE == 1)
            return ~(^d ^ p);
        else
            return ^d ^ p;
    endfunction

    // Two-flop synchroniser followed by the edge-history flop; runs in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign start_det = rx_d & ~rx_s;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic tap1, tap2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap1 <= 1'b1;
            tap2 <= 1'b1;
        end else begin
            tap1 <= rx_s;
            tap2 <= tap1;
        end
    end

    assign sample = majority3(tap2, tap1, rx_s);
`else
    assign sample = rx_s;
`endif

    assign at_h = (cnt == H_CNT);
    assign at_f = (cnt == F_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift_q        <= '0;
            par_pend       <= 1'b0;
            frm_pend       <= 1'b0;
            bus.rx_data    <= '0;
            bus.rx_valid   <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (start_det) begin
                        state    <= START;
                        bus.busy <= 1'b1;
                    end
                end
                START: begin
                    if (at_h) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        par_pend <= 1'b0;
                        frm_pend <= 1'b0;
                        // A high centre sample means the falling edge was a glitch
                        if (sample) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (at_f) begin
                        cnt     <= '0;
                        shift_q <= {sample, shift_q[DATA_BITS-1:1]};
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (at_f) begin
                        cnt      <= '0;
                        par_pend <= parity_error(shift_q, sample);
                        state    <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (at_f) begin
                        cnt <= '0;
                        if (!sample)
                            frm_pend <= 1'b1;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            state   <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.rx_data    <= shift_q;
                    bus.parity_err <= par_pend;
                    bus.frame_err  <= frm_pend;
                    bus.rx_valid   <= 1'b1;
                    bus.busy       <= 1'b0;
                    cnt            <= '0;
                    state          <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    bit_idx  <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Parametrised UART receiver: serial line in, parallel word out. Successor to the fixed 8N1 receive controller.
- Adds an input synchronizer, configurable data width, optional parity, 1 or 2 stop bits, and parity/framing error reporting.
- Sits between the board RX pin and the command/byte FIFO; downstream sees a one-clock valid strobe per received word.

Parameters:
CLKS_PER_BIT, 434, system clocks per bit (>= 8); 434 = 50 MHz / 115200
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
PARITY_MODE, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; every flop cleared immediately on assertion
rx  in  1  raw serial line, idle high, asynchronous to clk
rx_data  out  DATA_BITS  last received word; held until next completed frame
rx_valid  out  1  one-clock strobe: rx_data and error flags updated
parity_err  out  1  parity mismatch in last frame; 0 when PARITY_MODE=0
frame_err  out  1  a stop bit sampled low in last frame
busy  out  1  high in every state except IDLE

Behaviour:
Reset values:
- rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0.
- Synchronizer flops and edge-history flop = 1.
- state=IDLE; counter and bit index = 0.

Input path:
- rx passes through 2 flops (rx_s), then 1 history flop (rx_d).
- Start detect = rx_d & ~rx_s, a falling edge only. A line held low (break) never retriggers.

Counters:
- Clock counter width $clog2(CLKS_PER_BIT); reset to 0 on every state entry.
- H = CLKS_PER_BIT/2 - 1, the start-bit centre.
- F = CLKS_PER_BIT - 1, one full bit after the previous centre.
- Bit index width $clog2(DATA_BITS+1).

State machine:
- IDLE: counter held at 0. On start detect -> START.
- START: at count H, sample the line.
  - Sample high -> IDLE (glitch rejected; no strobe, no flag change).
  - Sample low -> DATA with counter=0, bit index=0.
- DATA: at count F, shift the sample into the word MSB side (LSB-first frame) and increment the bit index.
  - After the DATA_BITS-th sample -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: at count F, sample and compare with the XOR of the data.
  - Odd mode: total ones including the parity bit must be odd. Even mode: must be even.
  - -> STOP.
- STOP: at count F, sample each stop bit; any low sample sets a pending frame error.
  - After STOP_BITS samples -> DONE.
- DONE: a single cycle.
  - Load rx_data, parity_err and frame_err from the pending values; rx_valid=1.
  - -> IDLE. The falling-edge requirement prevents false starts during the remaining half stop bit.

Error and timing rules:
- Frame error does not suppress delivery: data is delivered with frame_err=1.
- Error flags are registered with rx_valid and held until the next rx_valid.
- Latency: rx_valid rises 1 clk after the last stop-bit centre sample; pin-to-decision adds 2 clk of synchronizer delay.
- Back-to-back frames: a new start edge arriving in the cycle DONE->IDLE is accepted because the edge history keeps running in all states.

Mid-operation cases:
- Reset mid-frame aborts the frame; no strobe is produced.
- The next falling edge after reset release starts a clean frame.
- An illegal state encoding -> IDLE.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: each decision at count X (H or F) uses the majority of line samples at counts X-2, X-1 and X. Two registered taps are combined with the current rx_s. Bit timing is unchanged.
- Undefined: the decision uses rx_s at count X only, and the tap registers are not instantiated.

Test Plan:
1. CLKS_PER_BIT=16, 8N1, send 0x55 -> rx_data=0x55, rx_valid high exactly 1 clk, parity_err=0, frame_err=0, busy low afterwards.
2. rx pulsed low 4 clk then high -> busy high then low, no rx_valid, rx_data unchanged.
3. PARITY_MODE=2, send 0xA5 with parity bit 1 (wrong) -> rx_data=0xA5, parity_err=1. A following frame 0x0F with parity 0 -> parity_err=0.
4. Send 0x3C with stop bit 0, then hold rx low 40 bit times, then release and send 0x81 -> first strobe frame_err=1 with data 0x3C; no strobe during the break; then 0x81 with frame_err=0.
5. Assert reset during data bit 4 of 0xFF, release, send 0x12 -> outputs 0 during reset, single strobe with rx_data=0x12.
6. Macro defined: 1-clk high glitch at data-bit-0 centre of 0x00 -> rx_data=0x00. Macro undefined -> rx_data=0x01.
